mul_share_arbiter: RTL and testbench

Shares one pipelined 56×56 multiplier among `N_REQ` requesters with round-robin arbitration, so that several modular-arithmetic engines can use a single DSP array. The block contains the multiplier instance (`multiplier_middle_bit`, 3-cycle latency, returns product bits [107:54]). It owns the operand mux, the operand registers and a tag pipeline that routes each result back to its requester. It accepts one request per cycle at full throughput and has no output backpressure.

---
 rtl/mul_share_arbiter.sv | 126 ++++++++++++
 tb/tb_mul_share_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one 3-stage pipelined 56x56 middle-bit multiplier
// among N_REQ requesters. A 4-stage {valid,id} tag pipeline runs alongside
// the operand register and the multiplier stages, and routes each result
// back to the requester that issued it.

// Pipelined multiplier returning product[2*RADIX-1:RADIX], 3-cycle latency.
module multiplier_middle_bit #(
  parameter int MUL_SIZE = 56,
  parameter int RADIX    = 54
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MUL_SIZE-1:0] a,
  input  logic [MUL_SIZE-1:0] b,
  output logic [RADIX-1:0]    res
);
  logic [2*MUL_SIZE-1:0] out;
  logic [2*MUL_SIZE-1:0] tmp;
  logic [RADIX-1:0]      res_t;

  // Multiply, retime, then slice the middle bits; sync clear keeps DSP regs simple.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out   <= '0;
      tmp   <= '0;
      res_t <= '0;
    end else begin
      out   <= {{MUL_SIZE{1'b0}}, a} * {{MUL_SIZE{1'b0}}, b};
      tmp   <= out;
      res_t <= tmp[2*RADIX-1:RADIX];
    end
  end

  assign res = res_t;
endmodule

module mul_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MUL_SIZE = 56,
  parameter int RADIX    = 54,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*MUL_SIZE-1:0] req_a,
  input  logic [N_REQ*MUL_SIZE-1:0] req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [RADIX-1:0]          res,
  output logic                      busy
);
  localparam int STAGES = 3;

  logic [ID_W-1:0]           ptr;
  logic [ID_W-1:0]           gidx;
  logic [ID_W-1:0]           idx;
  logic                      xfer;
  logic [N_REQ-1:0]          grant;
  logic [MUL_SIZE-1:0]       op_a;
  logic [MUL_SIZE-1:0]       op_b;
  logic [RADIX-1:0]          mul_res;
  logic [STAGES:0]           vld_pipe;
  logic [STAGES:0][ID_W-1:0] id_pipe;

  // Round-robin search from ptr; first asserted request wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    xfer  = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!xfer && req_valid[idx]) begin
        xfer        = 1'b1;
        gidx        = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

  assign req_ready = grant;

  // Pointer advance and operand capture on a transfer; operands hold otherwise
  // so the DSP inputs stay quiet on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= '0;
      op_a <= '0;
      op_b <= '0;
    end else if (xfer) begin
      ptr  <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      op_a <= req_a[gidx*MUL_SIZE +: MUL_SIZE];
      op_b <= req_b[gidx*MUL_SIZE +: MUL_SIZE];
    end
  end

  // Tag pipeline: stage 0 tracks the operand register, 1..3 track the multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], xfer};
      id_pipe  <= {id_pipe[STAGES-1:0], (xfer ? gidx : ID_W'(0))};
    end
  end

  multiplier_middle_bit #(
    .MUL_SIZE (MUL_SIZE),
    .RADIX    (RADIX)
  ) u_mul (
    .clk   (clk),
    .rst_n (~rst),
    .a     (op_a),
    .b     (op_b),
    .res   (mul_res)
  );

  assign res_valid = vld_pipe[STAGES];
  assign res_id    = id_pipe[STAGES];
  // Multiplier registers may hold stale data; only a valid tag exposes them.
  assign res       = vld_pipe[STAGES] ? mul_res : '0;
  assign busy      = |vld_pipe;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: table vectors, hand-written corner sequences
// and randomized traffic against a queue-based reference model.
module tb_mul_share_arbiter;
  localparam int N = 4;
  localparam int M = 56;
  localparam int R = 54;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*M-1:0] req_a;
  logic [N*M-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [R-1:0]   res;
  logic           busy;

  mul_share_arbiter #(.N_REQ(N), .MUL_SIZE(M), .RADIX(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res       (res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [R-1:0] val;
    int           due;
  } exp_t;

  typedef struct {
    int           id;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [R-1:0] val;
  } vec_t;

  exp_t         q[$];
  int           ptr_m;
  int           cyc;
  int           tests;
  int           fails;
  logic [M-1:0] opa[N];
  logic [M-1:0] opb[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare registered outputs against the model at the current cycle.
  task automatic check_out();
    logic bexp;
    bexp = (q.size() > 0) && (q[0].due - 3 <= cyc);
    chk("busy", 64'(busy), 64'(bexp));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("res_valid", 64'(res_valid), 64'd1);
      chk("res_id", 64'(res_id), 64'(q[0].id));
      chk("res", 64'(res), 64'(q[0].val));
      void'(q.pop_front());
    end else begin
      chk("res_valid_idle", 64'(res_valid), 64'd0);
      chk("res_idle_zero", 64'(res), 64'd0);
    end
  endtask

  // One cycle: check outputs, drive requests, check grant, update model, clock.
  task automatic drive(input logic [N-1:0] v, input bit tab, input logic [R-1:0] texp,
                       output logic [N-1:0] rr);
    int g;
    logic [2*M-1:0] p;
    exp_t e;
    check_out();
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*M +: M] = opa[i];
      req_b[i*M +: M] = opb[i];
    end
    #1;
    rr = req_ready;
    g  = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
    chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0) begin
      p     = {{M{1'b0}}, opa[g]} * {{M{1'b0}}, opb[g]};
      e.id  = g;
      e.val = tab ? texp : p[2*R-1:R];
      e.due = cyc + 4;
      q.push_back(e);
      ptr_m = (g + 1) % N;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic [N-1:0] rr;
    for (int i = 0; i < n; i++) drive('0, 1'b0, '0, rr);
  endtask

  vec_t vecs[5];

  initial begin
    logic [N-1:0] rr;
    logic [N-1:0] pend;
    logic [N-1:0] v;
    logic [63:0]  t;
    logic [M-1:0] mx;
    mx    = '1;
    tests = 0;
    fails = 0;
    cyc   = 0;
    ptr_m = 0;
    rst   = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end

    vecs[0] = '{0, 56'd1 << 54, 56'd5, 54'd5};
    vecs[1] = '{2, 56'd1 << 27, 56'd1 << 27, 54'd1};
    vecs[2] = '{1, (56'd3 << 54) | 56'd1, 56'd7, 54'd21};
    vecs[3] = '{2, 56'd1 << 55, 56'd1 << 55, 54'd0};
    vecs[4] = '{3, mx, mx, 54'h3FFFFFFFFFFFF8};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;

    // Table vectors: one requester for one cycle, then drain.
    for (int n = 0; n < 5; n++) begin
      opa[vecs[n].id] = vecs[n].a;
      opb[vecs[n].id] = vecs[n].b;
      drive(4'b1 << vecs[n].id, 1'b1, vecs[n].val, rr);
      chk("tab_grant", 64'(rr), 64'd1 << vecs[n].id);
      idle(5);
    end

    // Full load: pointer is 0 here, so the order is 0,1,2,3,0,1,2,3.
    for (int i = 0; i < N; i++) begin
      opa[i] = 56'(64'h1234_5678_9ABC + i * 64'h1_0000_0001);
      opb[i] = 56'(64'hFEDC_BA98_7654 - i * 64'h0_0300_0007);
    end
    for (int k = 0; k < 8; k++) begin
      drive(4'hF, 1'b0, '0, rr);
      chk("fair_grant", 64'(rr), 64'd1 << (k % 4));
    end
    idle(5);

    // Wrap-around sequences.
    drive(4'b1000, 1'b0, '0, rr); chk("wrap_g3", 64'(rr), 64'h8);
    drive(4'b1001, 1'b0, '0, rr); chk("wrap_g0", 64'(rr), 64'h1);
    drive(4'b1000, 1'b0, '0, rr); chk("wrap_g3b", 64'(rr), 64'h8);
    drive(4'b0100, 1'b0, '0, rr); chk("wrap_g2", 64'(rr), 64'h4);
    drive(4'b0001, 1'b0, '0, rr); chk("wrap_ptr3_g0", 64'(rr), 64'h1);
    drive(4'b0011, 1'b0, '0, rr); chk("wrap_ptr1_g1", 64'(rr), 64'h2);
    idle(5);

    // Reset mid-flight: grants 3,0,1 leave the pointer at 2.
    drive(4'b1000, 1'b0, '0, rr);
    drive(4'b0001, 1'b0, '0, rr);
    drive(4'b0010, 1'b0, '0, rr);
    req_valid = '0;
    @(posedge clk);
    cyc++;
    #2 rst = 1'b1;
    #1;
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    cyc++;
    #2 rst = 1'b0;
    q.delete();
    ptr_m = 0;
    @(negedge clk);
    idle(5);
    drive(4'b1010, 1'b0, '0, rr);
    chk("postrst_grant", 64'(rr), 64'h2);
    idle(6);

    // Randomized traffic; a waiting requester keeps its operands.
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          t = {$urandom(), $urandom()};
          opa[i] = ($urandom_range(0, 9) == 0) ? mx : t[M-1:0];
          t = {$urandom(), $urandom()};
          opb[i] = ($urandom_range(0, 9) == 0) ? mx : t[M-1:0];
        end
      end
      v = 4'($urandom_range(0, 15));
      drive(v, 1'b0, '0, rr);
      pend = v & ~rr;
    end
    req_valid = '0;
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
